// File: rtl/cmos_frame_window.sv
// Windowed pixel-stream conditioner: drops start-up frames, tracks x/y, crops a
// window, gates capture at frame starts and flags frames with a bad pixel count.
module cmos_frame_window #(
    parameter int IMG_H       = 1280,
    parameter int IMG_V       = 720,
    parameter int WIN_X0      = 0,
    parameter int WIN_Y0      = 0,
    parameter int WIN_W       = 1280,
    parameter int WIN_H       = 720,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [15:0] pdata_i,
    input  logic        cap_en_i,
    output logic        de_o,
    output logic [15:0] pdata_o,
    output logic        sof_o,
    output logic        eol_o,
    output logic        eof_o,
    output logic        frame_err_o
);

    localparam logic [11:0] H_LAST  = 12'(IMG_H - 1);
    localparam logic [11:0] V_END   = 12'(IMG_V);
    localparam logic [11:0] X0      = 12'(WIN_X0);
    localparam logic [11:0] Y0      = 12'(WIN_Y0);
    localparam logic [11:0] W_L     = 12'(WIN_W);
    localparam logic [11:0] H_L     = 12'(WIN_H);
    localparam logic [11:0] X_LAST  = 12'(WIN_X0 + WIN_W - 1);
    localparam logic [11:0] Y_LAST  = 12'(WIN_Y0 + WIN_H - 1);
    localparam logic [7:0]  SKIP_N  = 8'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        WAIT_VS,
        SKIP,
        RUN
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  skip_cnt, skip_cnt_nxt;
    logic [11:0] x, y;
    logic        vs_d, vs_armed, cap, ovf;
    logic        vs_rise, pix_acc, y_ok, in_win, out_pix;

    // A rise only counts once vs_i has been seen low after reset, so a sync
    // already high when reset releases is not taken as a frame start.
    assign vs_rise = vs_i & ~vs_d & vs_armed;
    assign pix_acc = de_i & ~vs_i;
    assign y_ok    = (y < V_END);
    // Unsigned wrap makes x < X0 fail the width test, giving a single compare.
    assign in_win  = ((x - X0) < W_L) && ((y - Y0) < H_L) && y_ok;
    assign out_pix = pix_acc && (state == RUN) && cap && in_win;

    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        case (state)
            WAIT_VS: begin
                if (vs_rise) begin
                    if (SKIP_N == 8'd0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt    = SKIP;
                        skip_cnt_nxt = 8'd1;
                    end
                end
            end
            SKIP: begin
                if (vs_rise) begin
                    if (skip_cnt == SKIP_N) state_nxt = RUN;
                    else                    skip_cnt_nxt = skip_cnt + 8'd1;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = WAIT_VS;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state       <= WAIT_VS;
            skip_cnt    <= '0;
            x           <= '0;
            y           <= '0;
            vs_d        <= 1'b0;
            vs_armed    <= 1'b0;
            cap         <= 1'b0;
            ovf         <= 1'b0;
            de_o        <= 1'b0;
            pdata_o     <= '0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
            eof_o       <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
            vs_d     <= vs_i;
            if (!vs_i) vs_armed <= 1'b1;

            if (vs_rise) begin
                x   <= '0;
                y   <= '0;
                ovf <= 1'b0;
            end else if (pix_acc) begin
                if (y_ok) begin
                    if (x == H_LAST) begin
                        x <= '0;
                        y <= y + 12'd1;
                    end else begin
                        x <= x + 12'd1;
                    end
                end else begin
                    ovf <= 1'b1;
                end
            end

            if (vs_rise && state_nxt == RUN) cap <= cap_en_i;

            frame_err_o <= vs_rise & cap & ((y != V_END) | (x != '0) | ovf);

            de_o  <= out_pix;
            sof_o <= out_pix && (x == X0) && (y == Y0);
            eol_o <= out_pix && (x == X_LAST);
            eof_o <= out_pix && (x == X_LAST) && (y == Y_LAST);
            if (out_pix) pdata_o <= pdata_i;
        end
    end

endmodule

// File: tb/tb_cmos_frame_window.sv
// Scoreboard bench for cmos_frame_window: full-window and cropped-window
// instances on an 8x4 image with two skipped frames.
module tb_cmos_frame_window;

    logic        clk = 1'b0;
    logic        rst_n, vs, de, cap_en;
    logic [15:0] pd;

    logic        f_de, f_sof, f_eol, f_eof, f_err;
    logic [15:0] f_pd;
    logic        w_de, w_sof, w_eol, w_eof, w_err;
    logic [15:0] w_pd;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  mk;
        int          cyc;
    } exp_t;

    exp_t q_full[$];
    exp_t q_win[$];
    exp_t ef, ew;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_err_f = 0;
    int n_err_w = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cmos_frame_window #(
        .IMG_H(8), .IMG_V(4), .WIN_X0(0), .WIN_Y0(0),
        .WIN_W(8), .WIN_H(4), .SKIP_FRAMES(2)
    ) u_full (
        .pclk(clk), .rst_n(rst_n), .vs_i(vs), .de_i(de), .pdata_i(pd),
        .cap_en_i(cap_en), .de_o(f_de), .pdata_o(f_pd), .sof_o(f_sof),
        .eol_o(f_eol), .eof_o(f_eof), .frame_err_o(f_err)
    );

    cmos_frame_window #(
        .IMG_H(8), .IMG_V(4), .WIN_X0(2), .WIN_Y0(1),
        .WIN_W(3), .WIN_H(2), .SKIP_FRAMES(2)
    ) u_win (
        .pclk(clk), .rst_n(rst_n), .vs_i(vs), .de_i(de), .pdata_i(pd),
        .cap_en_i(cap_en), .de_o(w_de), .pdata_o(w_pd), .sof_o(w_sof),
        .eol_o(w_eol), .eof_o(w_eof), .frame_err_o(w_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    always @(negedge clk) begin
        if (f_de) begin
            if (q_full.size() == 0) begin
                chk("full_unexpected_pixel", {31'd0, f_de}, 32'd0);
            end else begin
                ef = q_full.pop_front();
                chk("full_data", {16'd0, f_pd}, {16'd0, ef.data});
                chk("full_markers", {29'd0, f_sof, f_eol, f_eof}, {29'd0, ef.mk});
                chk("full_latency", cyc, ef.cyc);
            end
        end else if (f_sof | f_eol | f_eof) begin
            chk("full_marker_without_de", {29'd0, f_sof, f_eol, f_eof}, 32'd0);
        end
        if (w_de) begin
            if (q_win.size() == 0) begin
                chk("win_unexpected_pixel", {31'd0, w_de}, 32'd0);
            end else begin
                ew = q_win.pop_front();
                chk("win_data", {16'd0, w_pd}, {16'd0, ew.data});
                chk("win_markers", {29'd0, w_sof, w_eol, w_eof}, {29'd0, ew.mk});
                chk("win_latency", cyc, ew.cyc);
            end
        end else if (w_sof | w_eol | w_eof) begin
            chk("win_marker_without_de", {29'd0, w_sof, w_eol, w_eof}, 32'd0);
        end
        if (f_err) n_err_f++;
        if (w_err) n_err_w++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_full_de"},  {31'd0, f_de}, 32'd0);
        chk({tag, "_full_pd"},  {16'd0, f_pd}, 32'd0);
        chk({tag, "_full_mk"},  {28'd0, f_sof, f_eol, f_eof, f_err}, 32'd0);
        chk({tag, "_win_de"},   {31'd0, w_de}, 32'd0);
        chk({tag, "_win_pd"},   {16'd0, w_pd}, 32'd0);
        chk({tag, "_win_mk"},   {28'd0, w_sof, w_eol, w_eof, w_err}, 32'd0);
    endtask

    // One frame: sync pulse carrying stray de pulses, then npix ramp pixels.
    task automatic frame(input int fidx, input int npix, input bit captured,
                         input bit exp_err, input int mid_idx, input bit mid_val,
                         input int rst_at);
        int px, py;
        exp_t e;
        vs = 1'b1; de = 1'b1; pd = 16'hdead;
        tick();
        chk($sformatf("frame_err_full_f%0d", fidx), {31'd0, f_err}, {31'd0, exp_err});
        chk($sformatf("frame_err_win_f%0d", fidx),  {31'd0, w_err}, {31'd0, exp_err});
        pd = 16'hbeef;
        tick();
        de = 1'b0;
        tick();
        vs = 1'b0;
        tick();
        tick();
        for (int i = 0; i < npix; i++) begin
            if (i == mid_idx) cap_en = mid_val;
            px = i % 8;
            py = i / 8;
            de = 1'b1;
            pd = 16'(fidx * 256 + i);
            e.data = pd;
            e.cyc  = cyc + 1;
            if (captured && i < 32) begin
                e.mk = {i == 0, px == 7, i == 31};
                q_full.push_back(e);
                if (px >= 2 && px <= 4 && py >= 1 && py <= 2) begin
                    e.mk = {px == 2 && py == 1, px == 4, px == 4 && py == 2};
                    q_win.push_back(e);
                end
            end
            tick();
            de = 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk_zero($sformatf("midreset_f%0d", fidx));
                return;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; vs = 1'b1; de = 1'b0; pd = '0; cap_en = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        // sync still high from reset: no frame start, stray pixels ignored
        for (int k = 0; k < 4; k++) begin
            de = 1'b1; pd = 16'h1111;
            tick();
            de = 1'b0;
            tick();
        end
        vs = 1'b0;
        repeat (3) tick();

        frame(0, 32, 0, 0, -1, 0, -1);
        frame(1, 32, 0, 0, -1, 0, -1);
        frame(2, 32, 1, 0, -1, 0, -1);
        frame(3, 32, 1, 0, 10, 0, -1);
        frame(4, 32, 0, 0, 10, 1, -1);
        frame(5, 31, 1, 0, -1, 0, -1);
        frame(6, 33, 1, 1, -1, 0, -1);
        frame(7, 32, 1, 1, -1, 0, -1);
        frame(8, 32, 1, 0, -1, 0, 12);
        repeat (3) tick();
        frame(9, 32, 0, 0, -1, 0, -1);
        frame(10, 32, 0, 0, -1, 0, -1);
        frame(11, 32, 1, 0, -1, 0, -1);
        frame(12, 32, 1, 0, -1, 0, -1);
        repeat (5) tick();

        chk("full_queue_drained", q_full.size(), 0);
        chk("win_queue_drained", q_win.size(), 0);
        chk("full_err_pulses", n_err_f, 2);
        chk("win_err_pulses", n_err_w, 2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cmos_frame_window.md
# cmos_frame_window

Pixel-stream conditioner downstream of the OV5640 8→16-bit packer. Takes the packed RGB565 stream (one-cycle `de_i` pulses, active-high `vs_i`), discards the sensor's unstable start-up frames, tracks pixel/line position, crops a programmable window, gates capture on frame boundaries only, and emits the windowed stream with start-of-frame, end-of-line and end-of-frame markers for the frame-buffer write path. It also flags frames whose pixel count does not match the nominal geometry.

## Interface
- `IMG_H`, 1280, active pixels per input line (1..4095)
- `IMG_V`, 720, active lines per input frame (1..4095)
- `WIN_X0`, 0, first window column; `WIN_X0+WIN_W <= IMG_H`
- `WIN_Y0`, 0, first window line; `WIN_Y0+WIN_H <= IMG_V`
- `WIN_W`, 1280, window width (>=1)
- `WIN_H`, 720, window height (>=1)
- `SKIP_FRAMES`, 10, frames discarded after reset (0..255)
- `pclk` in 1 sensor pixel clock; only clock
- `rst_n` in 1 reset, synchronous, active-low
- `vs_i` in 1 frame sync, active high; rising edge starts a new frame
- `de_i` in 1 one-cycle pixel-valid pulse
- `pdata_i` in 16 RGB565 pixel, valid with `de_i`
- `cap_en_i` in 1 capture enable; takes effect only at a frame start
- `de_o` out 1 windowed pixel valid
- `pdata_o` out 16 windowed pixel
- `sof_o` out 1 with first window pixel of a captured frame
- `eol_o` out 1 with last pixel of each window line
- `eof_o` out 1 with last window pixel of a captured frame
- `frame_err_o` out 1 one-cycle pulse: previous captured frame had wrong pixel count

## Operation
- `vs_d` register; frame start `vs_rise = vs_i & ~vs_d`. `de_i` while `vs_i` high is ignored.
- Counters `x` (12 b) and `y` (12 b). On `vs_rise`: `x=0`, `y=0`. On accepted `de_i` while `y<IMG_V`: if `x==IMG_H-1` then `x=0`, `y=y+1`, else `x=x+1`. `y` holds at `IMG_V`; further pixels are overflow, never output, and mark the frame bad (`ovf` flag, cleared on `vs_rise`).
- State machine `state`:
  - WAIT_VS (reset): on `vs_rise` → RUN if `SKIP_FRAMES==0`, else SKIP with `skip_cnt=1`.
  - SKIP: on `vs_rise`, if `skip_cnt==SKIP_FRAMES` → RUN, else `skip_cnt++`. Frames 0..SKIP_FRAMES-1 produce no output.
  - RUN: stays until reset.
- `cap` flag: on every `vs_rise` in RUN (including the entering one), `cap = cap_en_i`; cleared on reset. Deasserting `cap_en_i` mid-frame completes the current frame.
- Pixel is in window when `WIN_X0<=x<WIN_X0+WIN_W`, `WIN_Y0<=y<WIN_Y0+WIN_H`, `y<IMG_V`. `de_o` = accepted `de_i` & RUN & `cap` & in window. `pdata_o` loads `pdata_i` only on such pixels, else holds.
- `sof_o` = `de_o` & `x==WIN_X0` & `y==WIN_Y0`; `eol_o` = `de_o` & `x==WIN_X0+WIN_W-1`; `eof_o` = `eol_o` & `y==WIN_Y0+WIN_H-1`.
- `frame_err_o` pulses on `vs_rise` when the ending frame was captured (`cap` was 1) and `(y!=IMG_V) | (x!=0) | ovf`. No check on the first RUN frame start (no prior captured frame).

## Timing
- All outputs registered; latency `de_i`/`pdata_i` → `de_o`/`pdata_o` is exactly 1 `pclk`. Markers aligned with `de_o`.
- `frame_err_o` is registered the cycle after the `vs_i` rising sample.
- Counter/window decisions use `x`,`y` before that pixel's increment.
- Reset values: `de_o`, `sof_o`, `eol_o`, `eof_o`, `frame_err_o` = 0; `pdata_o` = 16'h0000; state WAIT_VS, `x`,`y`,`skip_cnt`,`cap`,`ovf`,`vs_d` = 0.
- Reset mid-frame: outputs zero on the next edge; block then waits for a fresh `vs_rise` and repeats the full skip count.
- `vs_rise` and `de_i` in the same cycle: pixel ignored, counters cleared.
- `vs_i` held high from reset: no rise seen until it goes low and high again.

## Test plan
- `SKIP_FRAMES=2`, IMG 8×4, full window, `cap_en_i=1`, 4 frames with ramp data → frames 0,1 silent; frames 2,3 output 32 pixels each, first pixel = frame's first input, 1 cycle later.
- Window X0=2,Y0=1,W=3,H=2 on 8×4 → 6 pixels per frame; `sof_o` at (2,1), `eol_o` at x=4 on y=1,2, `eof_o` at (4,2).
- `cap_en_i` dropped mid-frame 3, raised mid-frame 4 → frame 3 complete, frame 4 silent, frame 5 captured.
- Captured frame with 31 pixels, then one with 33 → `frame_err_o` pulses at each following `vs_rise`; 33rd pixel not output; correct frame gives no pulse.
- `rst_n` low for 1 cycle mid-window → outputs 0 next cycle; skip count restarts from next `vs_rise`.
- `de_i` coincident with `vs_i` rise, and `de_i` while `vs_i` high → no output, next frame's first pixel at (0,0).
